// File: rtl/fp_div_seq.sv
// Sequential floating-point divider (op3 = op1 / op2) using restoring mantissa division.
// Define FP_DIV_ROUND_EN for round-to-nearest-even; otherwise the quotient fraction is truncated.
`timescale 1ns/1ps
module fp_div_seq #(
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned FRAC_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  op1_sign,
    input  logic [EXP_WIDTH-1:0]  op1_exp,
    input  logic [FRAC_WIDTH-1:0] op1_frac,
    input  logic                  op2_sign,
    input  logic [EXP_WIDTH-1:0]  op2_exp,
    input  logic [FRAC_WIDTH-1:0] op2_frac,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  op3_sign,
    output logic [EXP_WIDTH-1:0]  op3_exp,
    output logic [FRAC_WIDTH-1:0] op3_frac,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  div_by_zero
);

    localparam int unsigned N  = FRAC_WIDTH + 3;
    localparam int unsigned EW = EXP_WIDTH + 2;
    localparam int unsigned MW = FRAC_WIDTH + 1;
    localparam int unsigned RW = FRAC_WIDTH + 2;
    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [EW-1:0] BIAS  = EW'((1 << (EXP_WIDTH - 1)) - 1);
    localparam logic [EW-1:0] E_MAX = EW'((1 << EXP_WIDTH) - 1);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t state, state_next;

    logic                  sign_r;
    logic [EW-1:0]         e_r;
    logic                  z1_r, z2_r;
    logic [MW-1:0]         dvsr;
    logic [RW-1:0]         rem;
    logic [N-1:0]          q;
    logic [CW-1:0]         cnt;

    logic [RW:0]           diff;
    logic                  ge;
    logic [RW-1:0]         rem_next;

    logic [FRAC_WIDTH-1:0] n_frac;
    logic                  guard, sticky;
    logic [EW-1:0]         n_e;

    logic [EXP_WIDTH-1:0]  res_exp;
    logic [FRAC_WIDTH-1:0] res_frac;
    logic                  res_ovf, res_unf, res_dbz;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = DIV;
            DIV:     if (cnt == CW'(N - 1)) state_next = NORM;
            NORM:    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Restoring step: the partial remainder always stays below twice the divisor.
    always_comb begin
        diff     = {1'b0, rem} - {2'b00, dvsr};
        ge       = ~diff[RW];
        rem_next = ge ? {diff[RW-2:0], 1'b0} : {rem[RW-2:0], 1'b0};
    end

    always_comb begin
        if (q[N-1]) begin
            n_frac = q[N-2:2];
            guard  = q[1];
            sticky = q[0] | (|rem);
            n_e    = e_r;
        end else begin
            n_frac = q[N-3:1];
            guard  = q[0];
            sticky = |rem;
            n_e    = e_r - EW'(1);
        end
`ifdef FP_DIV_ROUND_EN
        if (guard && (sticky || n_frac[0])) begin
            if (&n_frac) n_e = n_e + EW'(1);
            n_frac = n_frac + FRAC_WIDTH'(1);
        end
`endif
    end

`ifndef FP_DIV_ROUND_EN
    logic unused_rnd;
    assign unused_rnd = guard ^ sticky;
`endif

    always_comb begin
        res_exp  = '0;
        res_frac = '0;
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
        res_dbz  = 1'b0;
        if (z2_r) begin
            res_exp = '1;
            res_dbz = 1'b1;
        end else if (z1_r) begin
            res_exp = '0;
        end else if ($signed(n_e) >= $signed(E_MAX)) begin
            res_exp = '1;
            res_ovf = 1'b1;
        end else if ($signed(n_e) <= 0) begin
            res_unf = 1'b1;
        end else begin
            res_exp  = n_e[EXP_WIDTH-1:0];
            res_frac = n_frac;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_r      <= 1'b0;
            e_r         <= '0;
            z1_r        <= 1'b0;
            z2_r        <= 1'b0;
            dvsr        <= '0;
            rem         <= '0;
            q           <= '0;
            cnt         <= '0;
            op3_sign    <= 1'b0;
            op3_exp     <= '0;
            op3_frac    <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign_r      <= op1_sign ^ op2_sign;
                    e_r         <= {2'b00, op1_exp} - {2'b00, op2_exp} + BIAS;
                    z1_r        <= (op1_exp == '0) && (op1_frac == '0);
                    z2_r        <= (op2_exp == '0) && (op2_frac == '0);
                    dvsr        <= {1'b1, op2_frac};
                    rem         <= {2'b01, op1_frac};
                    q           <= '0;
                    cnt         <= '0;
                    overflow    <= 1'b0;
                    underflow   <= 1'b0;
                    div_by_zero <= 1'b0;
                end
                DIV: begin
                    q   <= {q[N-2:0], ge};
                    rem <= rem_next;
                    cnt <= cnt + CW'(1);
                end
                NORM: begin
                    op3_sign    <= sign_r;
                    op3_exp     <= res_exp;
                    op3_frac    <= res_frac;
                    overflow    <= res_ovf;
                    underflow   <= res_unf;
                    div_by_zero <= res_dbz;
                end
                default: ;
            endcase
        end
    end

endmodule
